// File: rtl/stream_buf_pkg.sv
// Shared state encoding, default parameters and index-width helper for the
// stream channel buffer.
package stream_buf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    localparam int unsigned DEF_WIDTH     = 32;
    localparam int unsigned DEF_DEPTH     = 8;
    localparam int unsigned DEF_CHANNELS  = 4;
    localparam int unsigned DEF_BURST_LEN = 4;

    // Index width that never collapses to zero bits for a single-entry range.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_channel_buffer_if.sv
// Multi-channel input stream plus single output stream; slave is the buffer side.
interface stream_channel_buffer_if
    import stream_buf_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned CHANNELS = DEF_CHANNELS
);
    localparam int unsigned CHAN_W = idx_w(CHANNELS);

    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_ready;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [CHAN_W-1:0]         out_chan;
    logic                      out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_chan
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_chan
    );

endinterface

// File: rtl/stream_channel_buffer_rr_arbiter.sv
// Round-robin grant: lowest-index requester at or after ptr, wrapping modulo CHANNELS.
module rr_arbiter
    import stream_buf_pkg::*;
#(
    parameter int unsigned CHANNELS = DEF_CHANNELS,
    localparam int unsigned PTR_W   = idx_w(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [PTR_W-1:0]    ptr,
    output logic [CHANNELS-1:0] gnt
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            idx = PTR_W'((32'(ptr) + i) % CHANNELS);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_channel_buffer.sv
// Round-robin multi-channel collector into a first-word fall-through FIFO with
// IDLE/ACTIVE/DRAIN control and a done pulse every BURST_LEN pops.
module stream_channel_buffer
    import stream_buf_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned CHANNELS  = DEF_CHANNELS,
    parameter int unsigned BURST_LEN = DEF_BURST_LEN,
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    clear,
    stream_channel_buffer_if.slave  bus,
    output logic [CNT_W-1:0]        count,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned CHAN_W = idx_w(CHANNELS);
    localparam int unsigned PC_W   = idx_w(BURST_LEN);

    state_t              state, state_next;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [WIDTH-1:0]    data_mem [DEPTH];
    logic [CHAN_W-1:0]   chan_mem [DEPTH];
    logic [CHAN_W-1:0]   rr_ptr, rr_next, grant_idx;
    logic [PC_W-1:0]     pop_cnt;
    logic [CHANNELS-1:0] gnt, in_ready;
    logic [WIDTH-1:0]    push_data;
    logic                full, empty, can_accept, push, pop;

    rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
        .req (bus.in_valid),
        .ptr (rr_ptr),
        .gnt (gnt)
    );

    always_comb begin
        grant_idx = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (gnt[c]) grant_idx = CHAN_W'(c);
        end
    end

    // Full is judged on the registered count, so a same-cycle pop never opens a slot.
    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign can_accept = (state == ACTIVE) && enable && !full && !clear;
    assign in_ready   = can_accept ? gnt : '0;
    assign push       = |(bus.in_valid & in_ready);
    assign pop        = !empty && bus.out_ready && !clear;
    assign push_data  = bus.in_data[grant_idx*WIDTH +: WIDTH];
    assign rr_next    = (grant_idx == CHAN_W'(CHANNELS - 1)) ? '0 : grant_idx + CHAN_W'(1);

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = !empty;
    assign bus.out_data  = data_mem[rd_ptr];
    assign bus.out_chan  = chan_mem[rd_ptr];
    assign busy          = (state != IDLE);

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (enable) state_next = ACTIVE;
                ACTIVE:  if (!enable) state_next = empty ? IDLE : DRAIN;
                DRAIN:   if (enable) state_next = ACTIVE;
                         else if (empty) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rr_ptr  <= '0;
            pop_cnt <= '0;
            done    <= 1'b0;
        end else if (clear) begin
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rr_ptr  <= '0;
            pop_cnt <= '0;
            done    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                rr_ptr <= rr_next;
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);

            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            done <= 1'b0;
            if (pop) begin
                if (pop_cnt == PC_W'(BURST_LEN - 1)) begin
                    pop_cnt <= '0;
                    done    <= 1'b1;
                end else begin
                    pop_cnt <= pop_cnt + PC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= push_data;
            chan_mem[wr_ptr] <= grant_idx;
        end
    end

endmodule

// File: tb/tb_stream_channel_buffer.sv
// Self-checking bench: queue-based behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_stream_channel_buffer;
    import stream_buf_pkg::*;

    localparam int W  = 32;
    localparam int D  = 8;
    localparam int C  = 4;
    localparam int BL = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] count;
    logic       busy, done;

    stream_channel_buffer_if #(.WIDTH(W), .CHANNELS(C)) bus ();

    stream_channel_buffer #(
        .WIDTH(W), .DEPTH(D), .CHANNELS(C), .BURST_LEN(BL)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .clear   (clear),
        .bus     (bus),
        .count   (count),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 active, 2 drain; FIFO as a pair of queues.
    int          m_phase = 0;
    int          m_rr = 0;
    int          m_pops = 0;
    bit          m_done = 0;
    int          q_ch[$];
    logic [31:0] q_d[$];

    task automatic model_reset();
        m_phase = 0; m_rr = 0; m_pops = 0; m_done = 0;
        q_ch.delete(); q_d.delete();
    endtask

    function automatic logic [3:0] exp_ready();
        if (m_phase != 1 || !enable || clear || q_ch.size() == D) return 4'b0;
        for (int k = 0; k < C; k++) begin
            int ch;
            ch = (m_rr + k) % C;
            if (bus.in_valid[ch]) return 4'(1 << ch);
        end
        return 4'b0;
    endfunction

    always @(negedge clk) begin : cmp
        logic [3:0] er;
        int         nph, g;
        if (!reset_n) begin
            model_reset();
            chk("rst_in_ready", bus.in_ready, 0);
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_count", count, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
        end else begin
            er = exp_ready();
            chk("in_ready", bus.in_ready, er);
            chk("out_valid", bus.out_valid, q_ch.size() != 0);
            chk("count", count, q_ch.size());
            chk("busy", busy, m_phase != 0);
            chk("done", done, m_done);
            if (q_ch.size() != 0) begin
                chk("out_data", bus.out_data, q_d[0]);
                chk("out_chan", bus.out_chan, q_ch[0]);
            end
            if (clear) begin
                model_reset();
            end else begin
                nph = m_phase;
                case (m_phase)
                    0: if (enable) nph = 1;
                    1: if (!enable) nph = (q_ch.size() > 0) ? 2 : 0;
                    default: if (enable) nph = 1; else if (q_ch.size() == 0) nph = 0;
                endcase
                m_done = 0;
                if (q_ch.size() > 0 && bus.out_ready) begin
                    void'(q_ch.pop_front());
                    void'(q_d.pop_front());
                    if (m_pops == BL - 1) begin m_pops = 0; m_done = 1; end
                    else m_pops++;
                end
                if (er != 0) begin
                    g = $clog2(er);
                    q_ch.push_back(g);
                    q_d.push_back(bus.in_data[g*W +: W]);
                    m_rr = (g + 1) % C;
                end
                m_phase = nph;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_clear();
        step(); clear = 1'b1;
        step(); clear = 1'b0;
    endtask

    // Clear, let the FSM enter ACTIVE, then push n words on channel 0 with no pops.
    task automatic refill(input int n);
        bus.out_ready = 1'b0; enable = 1'b1; bus.in_valid = '0;
        do_clear();
        step();
        bus.in_valid = 4'b0001;
        bus.in_data = {$urandom, $urandom, $urandom, $urandom};
        repeat (n) begin
            step();
            bus.in_data = {$urandom, $urandom, $urandom, $urandom};
        end
        bus.in_valid = '0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin : main
        int grants[$];
        int chans[$];
        int n_done, t1, t2;

        bus.in_valid = '0; bus.in_data = '0; bus.out_ready = 1'b0;
        #1;
        chk("init_out_valid", bus.out_valid, 0);
        chk("init_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Single word on channel 0.
        enable = 1'b1;
        bus.in_valid = 4'b0001;
        bus.in_data = '0;
        bus.in_data[31:0] = 32'hA5A5A5A5;
        @(posedge clk); @(posedge clk); #1;
        bus.in_valid = '0;
        @(negedge clk);
        chk("single_busy", busy, 1);
        chk("single_out_valid", bus.out_valid, 1);
        chk("single_out_data", bus.out_data, 32'hA5A5A5A5);
        chk("single_out_chan", bus.out_chan, 0);
        chk("single_count", count, 1);

        // Fairness with all channels requesting and the consumer always ready.
        do_clear();
        bus.in_valid = 4'hF; bus.out_ready = 1'b1;
        for (int i = 0; i < 16 && grants.size() < 8; i++) begin
            @(negedge clk);
            if (bus.in_ready != 0) grants.push_back($clog2(bus.in_ready));
            if (bus.out_valid) chans.push_back(int'(bus.out_chan));
            step();
            bus.in_data = {$urandom, $urandom, $urandom, $urandom};
        end
        chk("fair_grant_total", grants.size(), 8);
        foreach (grants[k]) chk("fair_grant", grants[k], k % C);
        foreach (chans[k]) chk("fair_out_chan", chans[k], k % C);
        bus.in_valid = '0;
        repeat (3) step();

        // Full FIFO blocks the ninth attempt; a pop does not admit a same-cycle push.
        bus.out_ready = 1'b0;
        do_clear();
        step();
        bus.in_valid = 4'b0001;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 8) begin
                chk("full_count", count, 8);
                chk("full_in_ready", bus.in_ready, 0);
            end
            step();
            bus.in_data = {$urandom, $urandom, $urandom, $urandom};
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_no_push", bus.in_ready, 0);
        step();
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("full_after_pop_count", count, 7);
        chk("full_after_pop_ready", bus.in_ready, 4'b0001);
        step();
        bus.in_valid = '0;
        @(negedge clk);
        chk("full_refilled", count, 8);

        // Burst: eight back-to-back pops give two done pulses four cycles apart.
        refill(8);
        @(negedge clk);
        chk("burst_count", count, 8);
        step();
        bus.out_ready = 1'b1;
        n_done = 0; t1 = -1; t2 = -1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (t1 < 0) t1 = i; else t2 = i;
            end
        end
        chk("burst_done_pulses", n_done, 2);
        chk("burst_done_gap", t2 - t1, 4);
        bus.out_ready = 1'b0;

        // Drain: three queued words, enable dropped.
        refill(3);
        enable = 1'b0; bus.in_valid = 4'b0101;
        step();
        @(negedge clk);
        chk("drain_busy", busy, 1);
        chk("drain_in_ready", bus.in_ready, 0);
        chk("drain_count", count, 3);
        step();
        bus.out_ready = 1'b1;
        repeat (3) step();
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("drain_empty", count, 0);
        step();
        @(negedge clk);
        chk("drain_idle", busy, 0);
        bus.in_valid = '0; enable = 1'b1;

        // Clear beats a simultaneous push.
        refill(5);
        bus.in_valid = 4'b0001; clear = 1'b1;
        @(negedge clk);
        chk("clear_count_before", count, 5);
        chk("clear_in_ready", bus.in_ready, 0);
        step();
        clear = 1'b0; bus.in_valid = '0;
        @(negedge clk);
        chk("clear_count", count, 0);
        chk("clear_out_valid", bus.out_valid, 0);

        // Randomized traffic with two consumer duty cycles.
        for (int ph = 0; ph < 2; ph++) begin
            repeat (1500) begin
                step();
                enable       = ($urandom % 8) != 0;
                clear        = ($urandom % 64) == 0;
                bus.in_valid = 4'($urandom);
                bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
                bus.out_ready = (ph == 0) ? (($urandom % 3) == 0) : (($urandom % 3) != 0);
            end
        end

        // Asynchronous reset in the middle of a burst.
        step();
        clear = 1'b0; enable = 1'b1; bus.out_ready = 1'b1; bus.in_valid = 4'hF;
        repeat (6) step();
        #1 reset_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", bus.out_valid, 0);
        chk("rst_mid_count", count, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_in_ready", bus.in_ready, 0);
        repeat (2) step();
        bus.in_valid = '0; bus.out_ready = 1'b0;
        reset_n = 1'b1;
        repeat (2) step();
        @(negedge clk);
        chk("post_rst_count", count, 0);
        chk("post_rst_done", done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
